// File: rtl/flash_dump_seq.sv
// flash_dump_seq: parses "r AAAAAA LL CR" dump commands from the UART receiver,
// reads LL+1 bytes from the QPI flash reader starting at AAAAAA and forwards each
// byte to the UART transmit path.
//
// Handshakes (all pulses are registered, one cycle wide):
//   rx:  rx_valid holds a byte; rx_read consumes it. rx_valid is ignored in the
//        cycle rx_read is high and the cycle after, so a receiver that drops
//        rx_valid late never causes a double consume.
//   spi: spi_read starts one read at spi_addr; spi_addr stays put until the
//        matching spi_ready pulse, which is honoured only in RD_WAIT.
//   out: out_write presents out_data; out_ready (transmitter idle) is ignored in
//        the out_write cycle and the cycle after, giving the transmitter time
//        to drop it.
module flash_dump_seq #(
    parameter int TIMEOUT = 27_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_read,
    output logic        spi_read,
    output logic [23:0] spi_addr,
    input  logic        spi_ready,
    input  logic [7:0]  spi_data,
    output logic        out_write,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        err,
    output logic [2:0]  fsm_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_TERM    = 3'd3;
    localparam logic [2:0] S_RD      = 3'd4;
    localparam logic [2:0] S_RD_WAIT = 3'd5;
    localparam logic [2:0] S_TX_WAIT = 3'd6;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    logic [2:0]  state;
    logic [23:0] addr;
    logic [7:0]  len;
    logic [8:0]  remaining;
    logic [2:0]  digit_cnt;
    logic [31:0] idle_cnt;
    logic        rx_guard;
    logic        tx_guard;
    logic [4:0]  hex;
    logic        parsing;
    logic        take;
    logic        tx_accept;

    // Returns {valid, nibble} for an ASCII hex digit (either case).
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
        else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
        else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
        return r;
    endfunction

    // Decode the held byte and qualify receive / transmit acceptance.
    always_comb begin
        hex       = hex_decode(rx_data);
        parsing   = (state == S_ADDR) || (state == S_LEN) || (state == S_TERM);
        take      = rx_valid && !rx_read && !rx_guard && (parsing || state == S_IDLE);
        tx_accept = out_ready && !out_write && !tx_guard;
    end

    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    // Command parser, read issue and burst bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= 24'd0;
            len       <= 8'd0;
            remaining <= 9'd0;
            digit_cnt <= 3'd0;
            idle_cnt  <= 32'd0;
            rx_guard  <= 1'b0;
            tx_guard  <= 1'b0;
            rx_read   <= 1'b0;
            spi_read  <= 1'b0;
            spi_addr  <= 24'd0;
            out_write <= 1'b0;
            out_data  <= 8'd0;
            err       <= 1'b0;
        end else begin
            rx_read   <= 1'b0;
            spi_read  <= 1'b0;
            out_write <= 1'b0;
            err       <= 1'b0;
            rx_guard  <= rx_read;
            tx_guard  <= out_write;
            case (state)
                S_IDLE: begin
                    if (take) begin
                        rx_read <= 1'b1;
                        if (rx_data == 8'h72) begin
                            state     <= S_ADDR;
                            digit_cnt <= 3'd0;
                            idle_cnt  <= 32'd0;
                        end
                    end
                end
                S_ADDR, S_LEN, S_TERM: begin
                    if (take) begin
                        rx_read  <= 1'b1;
                        idle_cnt <= 32'd0;
                        if (state == S_TERM) begin
                            if (rx_data == 8'h0D) begin
                                remaining <= {1'b0, len} + 9'd1;
                                state     <= S_RD;
                            end else begin
                                err   <= 1'b1;
                                state <= S_IDLE;
                            end
                        end else if (!hex[4]) begin
                            err   <= 1'b1;
                            state <= S_IDLE;
                        end else if (state == S_ADDR) begin
                            addr <= {addr[19:0], hex[3:0]};
                            if (digit_cnt == 3'd5) begin
                                digit_cnt <= 3'd0;
                                state     <= S_LEN;
                            end else begin
                                digit_cnt <= digit_cnt + 3'd1;
                            end
                        end else begin
                            len <= {len[3:0], hex[3:0]};
                            if (digit_cnt == 3'd1) begin
                                digit_cnt <= 3'd0;
                                state     <= S_TERM;
                            end else begin
                                digit_cnt <= digit_cnt + 3'd1;
                            end
                        end
                    end else if (idle_cnt == TIMEOUT_LAST) begin
                        err      <= 1'b1;
                        idle_cnt <= 32'd0;
                        state    <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                S_RD: begin
                    spi_read <= 1'b1;
                    spi_addr <= addr;
                    state    <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (spi_ready) begin
                        out_data  <= spi_data;
                        out_write <= 1'b1;
                        state     <= S_TX_WAIT;
                    end
                end
                S_TX_WAIT: begin
                    // Follow-on reads are issued straight from here (rather than
                    // via S_RD) so spi_read lands the cycle after acceptance.
                    if (tx_accept) begin
                        addr      <= addr + 24'd1;
                        remaining <= remaining - 9'd1;
                        if (remaining == 9'd1) begin
                            state <= S_IDLE;
                        end else begin
                            spi_read <= 1'b1;
                            spi_addr <= addr + 24'd1;
                            state    <= S_RD_WAIT;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_dump_seq.sv
// Directed bench for flash_dump_seq: drives ASCII commands, models the flash
// reader (fixed latency, data = addr[7:0] ^ 0x5A) and the transmitter (busy for
// tx_delay cycles after each out_write), and checks addresses, data and timing.
module tb_flash_dump_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_read;
    logic        spi_read;
    logic [23:0] spi_addr;
    logic        spi_ready;
    logic [7:0]  spi_data;
    logic        out_write;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        busy;
    logic        err;
    logic [2:0]  fsm_state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int last_rx_cyc   = 0;
    int last_rdy_cyc  = 0;
    int last_ow_cyc   = 0;
    int err_cyc       = 0;
    int err_count     = 0;
    int ow_count      = 0;
    int tx_delay      = 4;
    bit first_rd      = 1'b0;
    logic [7:0]  last_flash_data = 8'd0;
    logic [23:0] got_addr_q[$];
    logic [23:0] exp_q[$];

    flash_dump_seq #(.TIMEOUT(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_read   (rx_read),
        .spi_read  (spi_read),
        .spi_addr  (spi_addr),
        .spi_ready (spi_ready),
        .spi_data  (spi_data),
        .out_write (out_write),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .err       (err),
        .fsm_state (fsm_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Flash reader model: answers each spi_read three cycles later.
    initial begin
        spi_ready = 1'b0;
        spi_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (spi_read) begin
                logic [23:0] a;
                a = spi_addr;
                repeat (3) @(negedge clk);
                spi_ready       = 1'b1;
                spi_data        = a[7:0] ^ 8'h5A;
                last_flash_data = spi_data;
                @(negedge clk);
                spi_ready = 1'b0;
            end
        end
    end

    // Transmitter model: busy for tx_delay cycles after each out_write (0 = never busy).
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (out_write && tx_delay != 0) begin
                out_ready = 1'b0;
                repeat (tx_delay) @(negedge clk);
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: records pulses and checks pulse-to-pulse latencies.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_read) last_rx_cyc = cyc;
            if (spi_ready) last_rdy_cyc = cyc;
            if (spi_read) begin
                got_addr_q.push_back(spi_addr);
                if (first_rd) begin
                    check("first_rd_latency", cyc, last_rx_cyc + 1);
                    first_rd = 1'b0;
                end else begin
                    check("next_rd_gap", cyc - last_ow_cyc, (tx_delay < 2) ? 3 : tx_delay + 1);
                end
            end
            if (out_write) begin
                check("ow_latency", cyc, last_rdy_cyc + 1);
                check("ow_data", out_data, last_flash_data);
                ow_count++;
                last_ow_cyc = cyc;
            end
            if (err) begin
                err_count++;
                err_cyc = cyc;
            end
        end
    end

    // Present one byte, wait for rx_read, keep rx_valid up through the guard cycle.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        while (!rx_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rx_consumed", rx_read, 1);
        repeat (2) @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic start_cmd();
        got_addr_q.delete();
        ow_count  = 0;
        err_count = 0;
        first_rd  = 1'b1;
    endtask

    // Wait for the burst to finish; busy must drop one cycle after the last acceptance.
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("burst_end", busy, 0);
        check("busy_drop_cycle", cyc - last_ow_cyc, (tx_delay < 2) ? 3 : tx_delay + 1);
    endtask

    task automatic check_addrs(input string tag);
        check({tag, "_nreads"}, got_addr_q.size(), exp_q.size());
        check({tag, "_nwrites"}, ow_count, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, "_addr"}, (i < got_addr_q.size()) ? got_addr_q[i] : 24'hxxxxxx, exp_q[i]);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_busy", busy, 0);
        check("rst_state", fsm_state, 0);
        check("rst_pulses", {rx_read, spi_read, out_write, err}, 4'b0000);
        check("rst_spi_addr", spi_addr, 24'h000000);
        check("rst_out_data", out_data, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // Single-byte dump.
        tx_delay = 4;
        start_cmd();
        send_str("r40000000");
        send_byte(8'h0D);
        wait_idle();
        exp_q = '{24'h400000};
        check_addrs("single");
        check("single_data", out_data, 8'h5A);

        // Four-byte burst crossing a 256-byte boundary.
        start_cmd();
        send_str("r4000FE03");
        send_byte(8'h0D);
        wait_idle();
        exp_q = '{24'h4000FE, 24'h4000FF, 24'h400100, 24'h400101};
        check_addrs("burst");
        check("burst_last_data", out_data, 8'h5B);

        // Lowercase hex, address wrap, transmitter always idle.
        tx_delay = 0;
        start_cmd();
        send_str("rfffffe02");
        send_byte(8'h0D);
        wait_idle();
        exp_q = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000};
        check("wrap_err", err_count, 0);
        check_addrs("wrap");
        check("wrap_last_data", out_data, 8'h5A);
        tx_delay = 4;

        // Stray byte in IDLE is dropped silently.
        start_cmd();
        send_byte(8'h78);
        repeat (3) @(negedge clk);
        check("stray_err", err_count, 0);
        check("stray_state", fsm_state, 0);

        // Parse error on a non-hex digit, then a good command.
        start_cmd();
        send_str("r40G");
        repeat (3) @(negedge clk);
        check("perr_count", err_count, 1);
        check("perr_cycle", err_cyc, last_rx_cyc);
        check("perr_state", fsm_state, 0);
        check("perr_no_read", got_addr_q.size(), 0);
        start_cmd();
        send_str("r12345600");
        send_byte(8'h0D);
        wait_idle();
        exp_q = '{24'h123456};
        check_addrs("after_perr");
        check("after_perr_data", out_data, 8'h0C);

        // Timeout after a partial command.
        start_cmd();
        send_str("r40");
        begin
            int n;
            n = 0;
            while (err_count == 0 && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        check("tmo_count", err_count, 1);
        check("tmo_delay", err_cyc - last_rx_cyc, 100);
        @(negedge clk);
        check("tmo_busy", busy, 0);

        // Reset while a flash read is outstanding.
        start_cmd();
        send_str("r00000010");
        send_byte(8'h0D);
        begin
            int n;
            n = 0;
            while (fsm_state != 3'd5 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("rstb_in_rd_wait", fsm_state, 3'd5);
        rst = 1'b1;
        @(negedge clk);
        check("rstb_state", fsm_state, 0);
        check("rstb_busy", busy, 0);
        check("rstb_pulses", {rx_read, spi_read, out_write, err}, 4'b0000);
        check("rstb_out_data", out_data, 8'h00);
        check("rstb_spi_addr", spi_addr, 24'h000000);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rstb_late_ready_ignored", ow_count, 0);
        check("rstb_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
